prog_divide_counter: RTL and testbench
======================================

Name: prog_divide_counter

Overview:
- Parametrised, runtime-programmable divide-by-N counter; the successor to the fixed divide-by-5 counter.
- The divisor is loaded at run time and can be changed without glitches; a new divisor takes effect only at a wrap.
- Three output modes: terminal-state pulse, near-50% square wave, and triggered one-shot.
- Sits in the SoC timing/event path; divides a clock or event stream, or generates periodic strobes for peripherals.

Parameters:
- WIDTH, 8, bit width of the counter and of the divisor.
- DEFAULT_DIV, 5, active divisor after reset; must satisfy 2 <= DEFAULT_DIV <= 2^WIDTH-1.

Ports:
- CLK  input  1  counter clock; all state updates on the falling edge.
- CLEAR  input  1  asynchronous, active-low reset.
- EN  input  1  count enable; counting advances only when EN=1.
- DIV  input  WIDTH  requested divisor, sampled when LOAD=1.
- LOAD  input  1  request to latch DIV as the pending divisor.
- MODE  input  2  00 pulse, 01 square, 10 one-shot, 11 treated as 00.
- START  input  1  one-shot trigger; ignored in other modes.
- Count  output  WIDTH  current count, range 0..Nact-1.
- OUT  output  1  mode-dependent divided output, registered.
- TC  output  1  one-cycle terminal-count strobe, registered.
- BUSY  output  1  one-shot run flag.
- ERR  output  1  sticky flag: an illegal divisor load was attempted.

Behaviour:
- CLEAR=0, asynchronous: Count=0, OUT=0, TC=0, BUSY=0, ERR=0, Nact=DEFAULT_DIV, pending slot empty.
- Internal registers: Nact (active divisor), Npend (pending divisor), pv (pending-valid flag).

Run condition:
- run = EN in modes 00/01/11.
- run = EN & BUSY in mode 10.

Count update, per falling edge:
- If run and Count==Nact-1: Count<=0. This is the wrap.
- Else if run: Count<=Count+1.
- Else: Count holds.

TC:
- TC<=1 on the wrap edge, else 0.
- TC is high for exactly one cycle per wrap.

Divisor load:
- LOAD=1 and DIV>=2: Npend<=DIV, pv<=1. A later LOAD overwrites an earlier one; the last value wins.
- LOAD=1 and DIV<2: the load is ignored and ERR<=1. ERR clears only on CLEAR.
- Npend applies (Nact<=Npend, pv<=0) on a wrap edge, or on any edge where run=0 and Count==0.
- LOAD on the same edge as the wrap: the old Npend (if pv) is applied; the new DIV becomes the pending value for the next wrap.
- Nact never changes mid-period, so Count never exceeds Nact-1.

OUT, registered, computed from the next Count value (cn) and the current Nact:
- Mode 00/11: OUT<=(cn==Nact-1). Same timing as the divide-by-5 block: for N=5, OUT is high while Count==4, i.e. 1 of every 5 cycles.
- Mode 01: OUT<=(cn < Nact>>1). N=5 gives 2 cycles high, 3 low; N=4 gives 2/2.
- Mode 10: as mode 00, gated by BUSY.
- When run=0, OUT holds its value.

One-shot (mode 10):
- START=1 with BUSY=0: BUSY<=1 and Count stays 0 on that edge.
- Subsequent run edges count 0..Nact-1.
- On the wrap: BUSY<=0, TC pulses, Count stays at 0.
- START while BUSY=1 is ignored.

Mode change:
- Takes effect on the next edge. Count continues from its current value; OUT is recomputed under the new mode.
- Leaving mode 10 forces BUSY<=0 on that edge.

Overflow:
- Nact up to 2^WIDTH-1; Count never wraps past all-ones.

Test Plan:
- Reset, MODE=00, EN=1, 12 falling edges → Count 1,2,3,4,0,1,2,3,4,0,1,2; OUT=1 only while Count=4; TC high the cycle after each 4→0 wrap.
- LOAD DIV=3 while Count=1 (Nact=5) → counting continues to 4 and wraps, then runs 0,1,2,0; no mid-period change. A LOAD of DIV=7 on the wrap edge takes effect one period later.
- LOAD DIV=1, then DIV=0 → ERR=1 and stays 1; Nact unchanged at 5; only CLEAR clears ERR.
- MODE=01, DIV=6 loaded while idle (EN=0, Count=0), then EN=1 for 12 edges → OUT pattern 1,1,1,0,0,0 repeating; MODE=01 with N=5 gives 1,1,0,0,0.
- MODE=10, EN=1, START pulse → BUSY=1; Count runs 0..4; TC pulses once; BUSY=0; Count holds 0. A second START during BUSY has no effect.
- CLEAR asserted asynchronously mid-count (Count=3, pending DIV=9) → all outputs 0 immediately; after release the counter runs with N=5 and the pending value is discarded.

Source files
------------

// File: rtl/prog_divide_counter.sv
// Runtime-programmable divide-by-N counter with pulse, square and one-shot outputs.
// All state advances on the falling edge of CLK; divisor changes land only at period boundaries.
module prog_divide_counter #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEFAULT_DIV = 5
) (
  input  logic             CLK,
  input  logic             CLEAR,
  input  logic             EN,
  input  logic [WIDTH-1:0] DIV,
  input  logic             LOAD,
  input  logic [1:0]       MODE,
  input  logic             START,
  output logic [WIDTH-1:0] Count,
  output logic             OUT,
  output logic             TC,
  output logic             BUSY,
  output logic             ERR
);

  localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO     = WIDTH'(2);

  logic [WIDTH-1:0] n_act;
  logic [WIDTH-1:0] n_pend;
  logic             pend_vld;

  logic             one_shot;
  logic             run;
  logic [WIDTH-1:0] last;
  logic             wrap;
  logic [WIDTH-1:0] cnt_nxt;
  logic             load_ok;
  logic             apply;
  logic             out_nxt;

  always_comb begin
    one_shot = (MODE == 2'b10);
    run      = EN & (~one_shot | BUSY);
    last     = n_act - ONE;
    wrap     = run & (Count == last);
    cnt_nxt  = wrap ? '0 : (run ? Count + ONE : Count);
    load_ok  = LOAD & (DIV >= TWO);
    // A pending divisor lands at a wrap, or whenever the counter sits parked at zero.
    apply    = pend_vld & (wrap | (~run & (Count == '0)));
    case (MODE)
      2'b01:   out_nxt = (cnt_nxt < (n_act >> 1));
      2'b10:   out_nxt = BUSY & (cnt_nxt == last);
      default: out_nxt = (cnt_nxt == last);
    endcase
  end

  always_ff @(negedge CLK or negedge CLEAR) begin
    if (!CLEAR) begin
      Count    <= '0;
      OUT      <= 1'b0;
      TC       <= 1'b0;
      BUSY     <= 1'b0;
      ERR      <= 1'b0;
      n_act    <= DIV_RST;
      pend_vld <= 1'b0;
    end else begin
      Count <= cnt_nxt;
      TC    <= wrap;
      if (run) OUT <= out_nxt;

      // A load coinciding with an apply re-arms the slot with the newer value.
      if (load_ok)    pend_vld <= 1'b1;
      else if (apply) pend_vld <= 1'b0;
      if (apply)      n_act    <= n_pend;
      if (LOAD && !load_ok) ERR <= 1'b1;

      if (!one_shot || wrap)  BUSY <= 1'b0;
      else if (START && !BUSY) BUSY <= 1'b1;
    end
  end

  // The pending value is only meaningful while pend_vld is set, so it needs no reset.
  always_ff @(negedge CLK) begin
    if (load_ok) n_pend <= DIV;
  end

endmodule

// File: tb/tb_prog_divide_counter.sv
// Directed bench for prog_divide_counter: hand-computed Count/OUT/TC sequences per mode.
module tb_prog_divide_counter;

  localparam int WIDTH = 8;

  logic             CLK;
  logic             CLEAR;
  logic             EN;
  logic [WIDTH-1:0] DIV;
  logic             LOAD;
  logic [1:0]       MODE;
  logic             START;
  logic [WIDTH-1:0] Count;
  logic             OUT;
  logic             TC;
  logic             BUSY;
  logic             ERR;

  int checks   = 0;
  int failures = 0;
  int prev_cnt = 0;

  prog_divide_counter #(.WIDTH(WIDTH), .DEFAULT_DIV(5)) dut (
    .CLK   (CLK),
    .CLEAR (CLEAR),
    .EN    (EN),
    .DIV   (DIV),
    .LOAD  (LOAD),
    .MODE  (MODE),
    .START (START),
    .Count (Count),
    .OUT   (OUT),
    .TC    (TC),
    .BUSY  (BUSY),
    .ERR   (ERR)
  );

  initial begin
    CLK = 1'b1;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One falling edge per character: expected Count digit and expected OUT bit.
  // TC is expected exactly on an edge that returns Count to 0 from a non-zero value.
  task automatic run_seq(input string tag, input string cnts, input string outs);
    for (int i = 0; i < cnts.len(); i++) begin
      int e;
      logic o;
      e = int'(cnts[i]) - 48;
      o = (outs[i] == 8'd49);
      @(negedge CLK);
      #1;
      chk({tag, "_cnt"}, 32'(Count), 32'(e));
      chk({tag, "_out"}, 32'(OUT), 32'(o));
      chk({tag, "_tc"}, 32'(TC), 32'((e == 0) && (prev_cnt != 0)));
      prev_cnt = e;
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_cnt"},  32'(Count), 32'd0);
    chk({tag, "_out"},  32'(OUT),   32'd0);
    chk({tag, "_tc"},   32'(TC),    32'd0);
    chk({tag, "_busy"}, 32'(BUSY),  32'd0);
    chk({tag, "_err"},  32'(ERR),   32'd0);
  endtask

  initial begin
    CLEAR = 1'b0;
    EN    = 1'b0;
    DIV   = '0;
    LOAD  = 1'b0;
    MODE  = 2'b00;
    START = 1'b0;
    #12;
    chk_reset_state("rst");
    CLEAR = 1'b1;
    EN    = 1'b1;

    // Default divide-by-5 pulse mode
    run_seq("pulse5", "123401234012", "000100001000");
    run_seq("pre_load", "3401", "0100");

    // Load 3 mid-period: the current period of 5 completes first
    LOAD = 1'b1; DIV = 8'd3;
    run_seq("load3", "2", "0");
    LOAD = 1'b0;
    run_seq("finish5", "340", "010");
    run_seq("period3", "120120", "010010");

    // Pending 4, then load 7 on the wrap edge: 4 applies now, 7 one period later
    run_seq("p3a", "1", "0");
    LOAD = 1'b1; DIV = 8'd4;
    run_seq("load4", "2", "1");
    DIV = 8'd7;
    run_seq("wrap_load7", "0", "0");
    LOAD = 1'b0;
    run_seq("period4", "1230", "0010");
    run_seq("period7", "1234560", "0000010");

    // Illegal divisors set a sticky error and leave the divisor alone
    LOAD = 1'b1; DIV = 8'd1;
    run_seq("err1", "1", "0");
    chk("err_div1", 32'(ERR), 32'd1);
    DIV = 8'd0;
    run_seq("err0", "2", "0");
    chk("err_div0", 32'(ERR), 32'd1);
    LOAD = 1'b0;
    run_seq("after_err", "345601234560", "000100000010");
    chk("err_sticky", 32'(ERR), 32'd1);

    // Idle load of 6 applies while parked at 0, then square mode
    EN = 1'b0; LOAD = 1'b1; DIV = 8'd6;
    run_seq("idle_load", "0", "0");
    LOAD = 1'b0;
    run_seq("idle_apply", "0", "0");
    MODE = 2'b01; EN = 1'b1;
    run_seq("sq6", "123450123450", "110001110001");
    LOAD = 1'b1; DIV = 8'd5;
    run_seq("sq_load5", "1", "1");
    LOAD = 1'b0;
    run_seq("sq6_end", "23450", "10001");
    run_seq("sq5", "1234012340", "1000110001");
    run_seq("sq5_tail", "1234", "1000");
    MODE = 2'b00;
    run_seq("back_pulse", "0", "0");

    // One-shot: START arms, one full period, then park at 0
    MODE = 2'b10; START = 1'b1;
    run_seq("os_start", "0", "0");
    chk("os_busy_set", 32'(BUSY), 32'd1);
    START = 1'b0;
    run_seq("os_run_a", "12", "00");
    START = 1'b1;
    run_seq("os_restart_ign", "3", "0");
    START = 1'b0;
    chk("os_busy_hold", 32'(BUSY), 32'd1);
    run_seq("os_run_b", "40", "10");
    chk("os_busy_clr", 32'(BUSY), 32'd0);
    run_seq("os_park", "00", "00");
    chk("os_busy_idle", 32'(BUSY), 32'd0);

    // Leaving one-shot mode mid-run drops BUSY and keeps counting
    START = 1'b1;
    run_seq("os2_start", "0", "0");
    START = 1'b0;
    run_seq("os2_run", "1", "0");
    MODE = 2'b00;
    run_seq("os2_leave", "2", "0");
    chk("os2_busy_drop", 32'(BUSY), 32'd0);

    // Asynchronous clear mid-count with a pending divisor of 9
    LOAD = 1'b1; DIV = 8'd9;
    run_seq("pend9", "3", "0");
    LOAD = 1'b0;
    #2 CLEAR = 1'b0;
    #1 chk_reset_state("clr");
    #2 CLEAR = 1'b1;
    prev_cnt = 0;
    run_seq("post_clear", "1234012340", "0001000010");
    chk("post_clear_err", 32'(ERR), 32'd0);

    MODE = 2'b11;
    run_seq("mode11", "12340", "00010");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
